// File: rtl/urv_periph_pkg.sv
// Shared definitions for the uRV data-memory console/timer responder:
// register offsets, STATUS layout and the bus handshake states.
package urv_periph_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_TIMER  = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_IRQ_BIT   = 2;
    localparam int STAT_LEVEL_LSB = 8;

    typedef enum logic [1:0] {
        BUS_IDLE      = 2'd0,
        BUS_WAIT_FIFO = 2'd1,
        BUS_DONE      = 2'd2
    } bus_state_e;

    // STATUS exposes a 4-bit level field regardless of the configured depth
    function automatic logic [3:0] sat_level4(input logic [31:0] lvl);
        return (lvl > 32'd15) ? 4'hF : lvl[3:0];
    endfunction

endpackage

// File: rtl/urv_byte_fifo.sv
// Synchronous byte FIFO with occupancy count; no write-to-read bypass.
module urv_byte_fifo
    import urv_periph_pkg::*;
#(
    parameter int unsigned g_log2_depth = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [7:0]              din_i,
    output logic [7:0]              dout_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [g_log2_depth:0]   level_o
);

    localparam int unsigned DEPTH = 1 << g_log2_depth;
    localparam int unsigned LVL_W = g_log2_depth + 1;

    logic [7:0]              mem [DEPTH];
    logic [g_log2_depth-1:0] wr_ptr_q, wr_ptr_d;
    logic [g_log2_depth-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    push_ok, pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign level_o = level_q;
    // Unwritten storage never reaches the pins while the FIFO is empty
    assign dout_o  = empty_o ? 8'h00 : mem[rd_ptr_q];

    always_comb begin
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/urv_dm_periph.sv
// Console + IRQ-timer responder on the uRV data-memory bus.
//   state         | meaning
//   BUS_IDLE      | waiting for dm_store_i / dm_load_i; access performed here
//   BUS_WAIT_FIFO | TXDATA store held off until the FIFO has room
//   BUS_DONE      | one-cycle done pulse; requests ignored
module urv_dm_periph
    import urv_periph_pkg::*;
#(
    parameter logic [31:0] g_base_addr       = 32'h0010_0000,
    parameter int unsigned g_fifo_log2_depth = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_store_done_o,
    output logic        dm_load_done_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        irq_o
);

    bus_state_e  state_q, state_d;
    logic        is_load_q, is_load_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  pend_byte_q, pend_byte_d;
    logic [7:0]  count_q, count_d;
    logic        irq_q, irq_d;

    logic                         fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [7:0]                   fifo_din, fifo_dout;
    logic [g_fifo_log2_depth:0]   fifo_level;

    logic        in_window, lane0, hit_txdata, hit_timer, timer_wr;
    logic [1:0]  reg_idx;
    logic [31:0] status_w, rd_word;
    logic        unused_ok;

    assign unused_ok  = ^{dm_addr_i[1:0], dm_data_s_i[31:8], dm_data_select_i[3:1]};

    // Low address nibble is the register offset, so the base is compared above it
    assign in_window  = (dm_addr_i[31:4] == g_base_addr[31:4]);
    assign reg_idx    = dm_addr_i[3:2];
    assign lane0      = dm_data_select_i[0];
    assign hit_txdata = in_window && lane0 && (reg_idx == REG_TXDATA);
    assign hit_timer  = in_window && lane0 && (reg_idx == REG_TIMER);

    urv_byte_fifo #(
        .g_log2_depth (g_fifo_log2_depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    assign tx_valid_o = !fifo_empty;
    assign tx_data_o  = fifo_dout;
    assign fifo_pop   = tx_valid_o && tx_ready_i;

    always_comb begin
        status_w = '0;
        status_w[STAT_EMPTY_BIT] = fifo_empty;
        status_w[STAT_FULL_BIT]  = fifo_full;
        status_w[STAT_IRQ_BIT]   = irq_q;
        status_w[STAT_LEVEL_LSB +: 4] = sat_level4(32'(fifo_level));
    end

    always_comb begin
        rd_word = '0;
        if (in_window) begin
            case (reg_idx)
                REG_TIMER:  rd_word = {24'h0, count_q};
                REG_STATUS: rd_word = status_w;
                default:    rd_word = '0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        is_load_d   = is_load_q;
        rdata_d     = rdata_q;
        pend_byte_d = pend_byte_q;
        fifo_push   = 1'b0;
        timer_wr    = 1'b0;
        fifo_din    = (state_q == BUS_WAIT_FIFO) ? pend_byte_q : dm_data_s_i[7:0];
        case (state_q)
            BUS_IDLE: begin
                if (dm_store_i) begin
                    is_load_d = 1'b0;
                    if (hit_txdata && fifo_full) begin
                        pend_byte_d = dm_data_s_i[7:0];
                        state_d     = BUS_WAIT_FIFO;
                    end else begin
                        fifo_push = hit_txdata;
                        timer_wr  = hit_timer;
                        state_d   = BUS_DONE;
                    end
                end else if (dm_load_i) begin
                    is_load_d = 1'b1;
                    rdata_d   = rd_word;
                    state_d   = BUS_DONE;
                end
            end
            // full is sampled before this cycle's pop, so a full FIFO never
            // sees a simultaneous pop and push
            BUS_WAIT_FIFO: begin
                if (!fifo_full) begin
                    fifo_push = 1'b1;
                    state_d   = BUS_DONE;
                end
            end
            BUS_DONE: begin
                state_d = BUS_IDLE;
            end
            default: begin
                state_d = BUS_IDLE;
            end
        endcase
    end

    // A TIMER write overrides the decrement, including the expiry cycle
    always_comb begin
        count_d = count_q;
        irq_d   = irq_q;
        if (timer_wr) begin
            count_d = dm_data_s_i[7:0];
            irq_d   = 1'b0;
        end else if (count_q != 8'h00) begin
            count_d = count_q - 8'h01;
            if (count_q == 8'h01) begin
                irq_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= BUS_IDLE;
            is_load_q   <= 1'b0;
            rdata_q     <= '0;
            pend_byte_q <= '0;
            count_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_load_q   <= is_load_d;
            rdata_q     <= rdata_d;
            pend_byte_q <= pend_byte_d;
            count_q     <= count_d;
            irq_q       <= irq_d;
        end
    end

    assign dm_store_done_o = (state_q == BUS_DONE) && !is_load_q;
    assign dm_load_done_o  = (state_q == BUS_DONE) && is_load_q;
    assign dm_data_l_o     = dm_load_done_o ? rdata_q : 32'h0;
    assign irq_o           = irq_q;

endmodule

// File: tb/tb_urv_dm_periph.sv
// Directed + randomized bench for urv_dm_periph against a queue/timeline model.
module tb_urv_dm_periph;

    localparam logic [31:0] BASE = 32'h0010_0000;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_store_i;
    logic        dm_load_i;
    logic [31:0] dm_data_l_o;
    logic        dm_store_done_o;
    logic        dm_load_done_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        irq_o;

    urv_dm_periph #(
        .g_base_addr       (BASE),
        .g_fifo_log2_depth (3)
    ) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .dm_addr_i        (dm_addr_i),
        .dm_data_s_i      (dm_data_s_i),
        .dm_data_select_i (dm_data_select_i),
        .dm_store_i       (dm_store_i),
        .dm_load_i        (dm_load_i),
        .dm_data_l_o      (dm_data_l_o),
        .dm_store_done_o  (dm_store_done_o),
        .dm_load_done_o   (dm_load_done_o),
        .tx_data_o        (tx_data_o),
        .tx_valid_o       (tx_valid_o),
        .tx_ready_i       (tx_ready_i),
        .irq_o            (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // model: bytes accepted but not yet taken by the sink, and the last timer load
    logic [7:0] exp_q[$];
    int t_val = 0;
    int t_edge = 0;

    int         snap_cyc;
    logic       snap_valid;
    logic [7:0] snap_data;
    bit         rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int cnt_after(input int c);
        int el;
        el = c - t_edge;
        return (el >= t_val) ? 0 : t_val - el;
    endfunction

    function automatic bit irq_after(input int c);
        return (t_val != 0) && ((c - t_edge) >= t_val);
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input int c);
        if (a[31:4] != BASE[31:4]) return 32'h0;
        if (a[3:2] == 2'd1) return 32'(cnt_after(c));
        return 32'h0;
    endfunction

    function automatic logic [31:0] stat_exp(input int lvl, input bit irqv);
        logic [31:0] s;
        s = '0;
        s[0] = (lvl == 0);
        s[1] = (lvl == 8);
        s[2] = irqv;
        s[11:8] = (lvl > 15) ? 4'hF : 4'(lvl);
        return s;
    endfunction

    task automatic bus_op(input bit st, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] sel, output logic [31:0] rd, output int lat);
        bit got;
        bit in_win;
        got = 1'b0;
        lat = 1;
        in_win = (a[31:4] == BASE[31:4]);
        dm_addr_i = a;
        dm_data_s_i = d;
        dm_data_select_i = sel;
        dm_store_i = st;
        dm_load_i = !st;
        for (int i = 0; i < 64 && !got; i++) begin
            @(posedge clk_i); #1;
            lat++;
            got = st ? dm_store_done_o : dm_load_done_o;
        end
        chk("bus_done", 32'(got), 32'd1);
        snap_cyc = cyc;
        snap_valid = tx_valid_o;
        snap_data = tx_data_o;
        rd = dm_data_l_o;
        chk("other_done", 32'(st ? dm_load_done_o : dm_store_done_o), 32'd0);
        if (st) begin
            chk("store_data_l", dm_data_l_o, 32'd0);
            if (in_win && sel[0] && a[3:2] == 2'd0) exp_q.push_back(d[7:0]);
            if (in_win && sel[0] && a[3:2] == 2'd1) begin
                t_val = int'(d[7:0]);
                t_edge = cyc;
            end
        end else if (!(in_win && a[3:2] == 2'd2)) begin
            chk("load_data", rd, exp_load(a, cyc - 1));
        end
        chk("irq_at_done", 32'(irq_o), 32'(irq_after(cyc)));
        @(posedge clk_i); #1;
        chk("done_width", 32'({dm_store_done_o, dm_load_done_o}), 32'd0);
        chk("data_l_idle", dm_data_l_o, 32'd0);
        dm_store_i = 1'b0;
        dm_load_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1 && tx_valid_o && tx_ready_i) begin
            if (exp_q.size() == 0) chk("tx_unexpected", 32'(tx_valid_o), 32'd0);
            else chk("tx_order", 32'(tx_data_o), 32'(exp_q.pop_front()));
        end
    end

    always @(posedge clk_i) begin
        if (rand_rdy) begin
            #1;
            tx_ready_i = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int lat;
        int x;
        int op;

        rst_n_i = 1'b0;
        tx_ready_i = 1'b1;
        dm_addr_i = '0;
        dm_data_s_i = '0;
        dm_data_select_i = '0;
        dm_store_i = 1'b0;
        dm_load_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_outputs", {dm_data_l_o[23:0], tx_data_o}, 32'd0);
        chk("rst_flags", 32'({dm_store_done_o, dm_load_done_o, tx_valid_o, irq_o}), 32'd0);
        rst_n_i = 1'b1;
        t_edge = cyc;
        @(posedge clk_i); #1;

        // single console byte with an always-ready sink
        bus_op(1'b1, BASE, 32'h41, 4'hF, rd, lat);
        chk("st_latency", lat, 32'd2);
        chk("tx_valid_first", 32'(snap_valid), 32'd1);
        chk("tx_data_first", 32'(snap_data), 32'h41);
        chk("tx_popped", 32'(tx_valid_o), 32'd0);

        // fill the FIFO, then stall on the ninth byte
        tx_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_op(1'b1, BASE, 32'h30 + i, 4'hF, rd, lat);
            chk("fill_latency", lat, 32'd2);
        end
        bus_op(1'b0, BASE + 32'h8, 32'h0, 4'hF, rd, lat);
        chk("status_full", rd, 32'h0000_0802);
        chk("status_model", rd, stat_exp(exp_q.size(), irq_after(snap_cyc - 1)));
        fork
            bus_op(1'b1, BASE, 32'h38, 4'hF, rd, lat);
            begin
                repeat (6) @(posedge clk_i);
                #1;
                chk("stall_no_done", 32'(dm_store_done_o), 32'd0);
                tx_ready_i = 1'b1;
            end
        join
        chk("stall_latency", lat, 32'd9);
        x = 0;
        while (exp_q.size() != 0 && x < 100) begin
            @(posedge clk_i);
            x++;
        end
        #1;
        chk("drain_done", 32'(exp_q.size()), 32'd0);
        chk("drain_valid", 32'(tx_valid_o), 32'd0);

        // timer expiry, readback and disable
        bus_op(1'b1, BASE + 32'h4, 32'h05, 4'hF, rd, lat);
        x = snap_cyc;
        for (int k = 2; k <= 7; k++) begin
            @(posedge clk_i); #1;
            chk("irq_rise", 32'(irq_o), 32'(cyc >= x + 5));
        end
        bus_op(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, lat);
        chk("timer_rd_expired", rd, 32'd0);
        bus_op(1'b1, BASE + 32'h4, 32'h00, 4'hF, rd, lat);
        chk("irq_fall", 32'(irq_o), 32'd0);

        bus_op(1'b1, BASE + 32'h4, 32'h20, 4'hF, rd, lat);
        bus_op(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, lat);
        chk("timer_rd_1f", rd, 32'h1F);
        bus_op(1'b0, BASE, 32'h0, 4'hF, rd, lat);
        chk("txdata_rd", rd, 32'd0);
        bus_op(1'b0, BASE + 32'hC, 32'h0, 4'hF, rd, lat);
        chk("rsvd_rd", rd, 32'd0);

        // lane 0 disabled and out-of-window accesses
        bus_op(1'b1, BASE, 32'hFF, 4'b0010, rd, lat);
        chk("nolane_latency", lat, 32'd2);
        chk("nolane_empty", 32'(snap_valid), 32'd0);
        bus_op(1'b0, 32'h0020_0000, 32'h0, 4'hF, rd, lat);
        chk("oow_rd", rd, 32'd0);
        bus_op(1'b1, BASE + 32'h10, 32'h55, 4'hF, rd, lat);
        chk("oow_st_empty", 32'(snap_valid), 32'd0);

        // randomized traffic with a random-ready sink
        rand_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: bus_op(1'b1, BASE, $urandom, 4'($urandom_range(0, 15)), rd, lat);
                1: bus_op(1'b1, BASE + 32'h4, 32'($urandom_range(0, 40)),
                          4'($urandom_range(0, 15)), rd, lat);
                2: bus_op(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd, lat);
                3: bus_op(1'b0, ($urandom_range(0, 1) != 0) ? BASE + 32'hC : BASE,
                          32'h0, 4'hF, rd, lat);
                4: begin
                    a = ($urandom_range(0, 1) != 0) ? (32'h0020_0000 | 32'($urandom_range(0, 15)))
                                                    : (BASE + 32'h10 + 32'($urandom_range(0, 15)));
                    bus_op(1'($urandom_range(0, 1)), a, $urandom, 4'hF, rd, lat);
                end
                default: begin
                    x = $urandom_range(1, 45);
                    for (int k = 0; k < x; k++) begin
                        @(posedge clk_i); #1;
                        chk("rnd_irq", 32'(irq_o), 32'(irq_after(cyc)));
                    end
                end
            endcase
        end
        rand_rdy = 1'b0;
        @(posedge clk_i); #2;
        tx_ready_i = 1'b1;
        x = 0;
        while (exp_q.size() != 0 && x < 100) begin
            @(posedge clk_i);
            x++;
        end
        @(posedge clk_i); #1;
        chk("rnd_drain", 32'(exp_q.size()), 32'd0);
        bus_op(1'b0, BASE + 32'h8, 32'h0, 4'hF, rd, lat);
        chk("rnd_status", rd, stat_exp(0, irq_after(snap_cyc - 1)));

        // reset while a store is stalled on a full FIFO
        bus_op(1'b1, BASE + 32'h4, 32'h03, 4'hF, rd, lat);
        tx_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) bus_op(1'b1, BASE, 32'hA0 + i, 4'hF, rd, lat);
        chk("irq_before_reset", 32'(irq_o), 32'd1);
        dm_addr_i = BASE;
        dm_data_s_i = 32'h99;
        dm_data_select_i = 4'hF;
        dm_store_i = 1'b1;
        repeat (3) begin
            @(posedge clk_i); #1;
            chk("wait_no_done", 32'(dm_store_done_o), 32'd0);
        end
        rst_n_i = 1'b0;
        #1;
        chk("arst_flags", 32'({dm_store_done_o, dm_load_done_o, tx_valid_o, irq_o}), 32'd0);
        chk("arst_data", {dm_data_l_o[23:0], tx_data_o}, 32'd0);
        dm_store_i = 1'b0;
        exp_q.delete();
        t_val = 0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        t_edge = cyc;
        repeat (3) begin
            @(posedge clk_i); #1;
            chk("post_rst_quiet", 32'({dm_store_done_o, dm_load_done_o, tx_valid_o}), 32'd0);
        end
        bus_op(1'b0, BASE + 32'h8, 32'h0, 4'hF, rd, lat);
        chk("post_rst_status", rd, 32'h0000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/urv_dm_periph.md
Name: urv_dm_periph

Overview:
Synthesizable responder on the uRV data-memory bus, the slave end of the CPU's dm_* initiator interface. It implements the console and IRQ-timer peripherals at a fixed base address. Console stores go through a byte FIFO that drives a valid/ready TX stream; a countdown timer drives the CPU irq_i line. The block sits beside data RAM, selected by an address decode; it replaces the behavioural console and timer models used in simulation.

Parameters:
g_base_addr, 32'h0010_0000, base of the 16-byte peripheral window; must be 16-byte aligned.
g_fifo_log2_depth, 3, log2 of the TX FIFO depth (8 entries).

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
dm_addr_i  in  32  byte address from CPU
dm_data_s_i  in  32  store data
dm_data_select_i  in  4  byte lane enables
dm_store_i  in  1  store request, held until dm_store_done_o
dm_load_i  in  1  load request, held until dm_load_done_o
dm_data_l_o  out  32  load data, valid only while dm_load_done_o=1
dm_store_done_o  out  1  one-cycle store completion pulse
dm_load_done_o  out  1  one-cycle load completion pulse
tx_data_o  out  8  console byte at FIFO head
tx_valid_o  out  1  FIFO not empty
tx_ready_i  in  1  sink accepts tx_data_o when tx_valid_o and tx_ready_i are both 1
irq_o  out  1  timer interrupt to CPU, level

Behaviour:
- Reset: asynchronous on rst_n_i=0. All outputs go to 0. FIFO is empty, timer counter is 0, bus FSM is in IDLE.
- Register map, offset from g_base_addr, word index addr[3:2]:
  - 0x0 TXDATA: write pushes data[7:0]; read returns 0.
  - 0x4 TIMER: write loads count=data[7:0] and clears irq; read returns {24'0, count}.
  - 0x8 STATUS, read-only: bit0 fifo_empty, bit1 fifo_full, bit2 irq; bits[11:8] fifo level, saturating at 15.
  - 0xC: reserved; reads 0, writes ignored.
- A write takes effect only when dm_data_select_i[0]=1. It still completes otherwise.
- Addresses outside the window complete normally: stores are discarded and loads return 0.
- Bus FSM states are IDLE, WAIT_FIFO and DONE.
  - IDLE:
    - If dm_store_i=1 and the target is TXDATA with lane0 set and the FIFO is full, go to WAIT_FIFO.
    - Otherwise, on dm_store_i or dm_load_i, perform the access this cycle and go to DONE.
    - If both requests are high, the store takes priority and the load stays pending.
  - WAIT_FIFO: push on the first cycle the FIFO is not full, then go to DONE. A pop and a push in the same cycle on a full FIFO is not allowed: the push waits one cycle.
  - DONE: assert the matching done pulse for exactly this cycle, with dm_data_l_o registered from the IDLE-cycle read. Requests are ignored during DONE. Return to IDLE.
- Latency: 2 cycles from request to done. Stores that hit a full FIFO take 2 cycles plus the stall cycles.
- FIFO: synchronous, with no bypass, so a push into an empty FIFO is visible on tx_valid_o the next cycle. A pop happens when tx_valid_o and tx_ready_i are both 1. The pointer wraps modulo depth. The level stays correct when a push and a pop occur in the same cycle with level between 1 and depth-1.
- Timer: count decrements by 1 per cycle while nonzero.
  - When count==1, the next cycle gives irq=1 and count=0.
  - Writing 0 disables the timer and clears irq.
  - irq holds at 1 until the next TIMER write.
  - A TIMER write in the same cycle as expiry wins: irq stays 0 and count is loaded.
- Reset asserted mid-transaction aborts it with no done pulse. The CPU is reset by the same reset.

Decomposition:
- Shared package urv_periph_pkg holds:
  - the register offset constants (REG_TXDATA, REG_TIMER, REG_STATUS);
  - the STATUS bit positions;
  - the bus FSM enum.
- One sub-module, urv_byte_fifo (params: log2 depth). Ports: push, pop, din, dout, empty, full, level.

Test Plan:
- Reset with tx_ready_i=1; store 0x41 to 0x100000 -> dm_store_done_o pulses 2 cycles after the request; tx_valid_o=1 with tx_data_o=0x41 on the next cycle; it pops and tx_valid_o returns to 0.
- Hold tx_ready_i=0 and store 9 bytes 0x30..0x38 -> first 8 complete in 2 cycles each; the 9th stalls in WAIT_FIFO; STATUS reads 0x0000_0802. Raise tx_ready_i -> the 9th completes; bytes drain in order 0x30..0x38.
- Store 0x05 to 0x100004 -> irq_o rises exactly 5 cycles after the write cycle; TIMER reads 0. Store 0 -> irq_o falls the next cycle.
- Load TIMER right after writing 0x20 -> dm_data_l_o=0x1F or 0x1E per the cycle count, valid only in the done cycle. Load 0x100000 and 0x10000C -> 0.
- Store 0xFF to 0x100000 with dm_data_select_i=4'b0010 -> done pulse, FIFO stays empty. Load 0x00200000 -> done, data 0.
- Assert rst_n_i low for 1 cycle while in WAIT_FIFO -> all outputs 0 immediately; FIFO empty; no done pulse.
